timer_nch: RTL and testbench

- Parametrised N-channel timer, successor to the 8-bit timer IP.
- Each channel has a CNT_W-bit up/down counter, a per-channel 2^k prescaler, a free-wrap or auto-reload mode, and sticky overflow/underflow flags with a per-channel interrupt.
- All registers sit on a zero-wait APB slave in the peripheral subsystem.

---
 rtl/timer_nch_pkg.sv | 49 ++++
 rtl/timer_nch_channel.sv | 112 +++++++++++
 rtl/timer_nch.sv | 65 ++++++
 tb/tb_timer_nch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/timer_nch_pkg.sv
// Shared register map, control/status field layouts and address decode for timer_nch.
package timer_nch_pkg;

  localparam logic [4:0] OFF_TDR  = 5'h00;
  localparam logic [4:0] OFF_TCR  = 5'h04;
  localparam logic [4:0] OFF_TSR  = 5'h08;
  localparam logic [4:0] OFF_TIE  = 5'h0C;
  localparam logic [4:0] OFF_TCNT = 5'h10;

  localparam int TCR_EN   = 0;
  localparam int TCR_LOAD = 1;
  localparam int TCR_DIR  = 2;
  localparam int TCR_ARL  = 3;
  localparam int TCR_CKS  = 4;
  localparam int TSR_OVF  = 0;
  localparam int TSR_UDF  = 1;

  // Storage for CKS is sized for the largest supported PRESC_W; channels use the low bits.
  localparam int CKS_MAX_W = 5;

  typedef struct packed {
    logic [CKS_MAX_W-1:0] cks;
    logic                 arl;
    logic                 dir;
    logic                 load;
    logic                 en;
  } tcr_t;

  typedef struct packed {
    logic udf;
    logic ovf;
  } tsr_t;

  typedef enum logic [2:0] {
    REG_TDR, REG_TCR, REG_TSR, REG_TIE, REG_TCNT, REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [4:0] off);
    case (off)
      OFF_TDR:  decode_off = REG_TDR;
      OFF_TCR:  decode_off = REG_TCR;
      OFF_TSR:  decode_off = REG_TSR;
      OFF_TIE:  decode_off = REG_TIE;
      OFF_TCNT: decode_off = REG_TCNT;
      default:  decode_off = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/timer_nch_channel.sv
// One timer channel: prescaler, up/down counter, TDR/TCR/TSR/TIE registers and interrupt.
module timer_nch_channel
  import timer_nch_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  reg_sel_e    sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int DIV_W = (1 << PRESC_W) - 1;

  logic [CNT_W-1:0]   tdr, tcnt, cnt_next;
  tcr_t               tcr;
  tsr_t               tsr, tie, tsr_set, tsr_clr;
  logic [DIV_W-1:0]   div;
  logic [DIV_W:0]     div_top;
  logic [PRESC_W-1:0] cks, new_cks;
  logic               wr_tdr, wr_tcr, wr_tsr, wr_tie, load, cks_chg, tick;
  logic               unused_bits;

  assign wr_tdr  = wr && (sel == REG_TDR);
  assign wr_tcr  = wr && (sel == REG_TCR);
  assign wr_tsr  = wr && (sel == REG_TSR);
  assign wr_tie  = wr && (sel == REG_TIE);
  assign load    = wr_tcr && wdata[TCR_LOAD];
  assign cks     = tcr.cks[PRESC_W-1:0];
  assign new_cks = wdata[TCR_CKS +: PRESC_W];
  // Only a change of ratio restarts the divider, so DIR/ARL rewrites do not disturb the tick phase.
  assign cks_chg = wr_tcr && (new_cks != cks);
  assign div_top = ({{DIV_W{1'b0}}, 1'b1} << cks) - {{DIV_W{1'b0}}, 1'b1};
  assign tick    = tcr.en && ({1'b0, div} == div_top);
  assign tsr_clr = wr_tsr ? tsr_t'(wdata[TSR_UDF:TSR_OVF]) : tsr_t'(2'b00);
  assign irq     = |(tsr & tie);
  assign unused_bits = ^{wdata, tcr.load, tcr.cks};

  // Next counter value and wrap flags; LOAD takes precedence over a tick.
  always_comb begin
    cnt_next = tcnt;
    tsr_set  = tsr_t'(2'b00);
    if (load) begin
      cnt_next = tdr;
    end else if (tick && !tcr.dir) begin
      if (tcnt == {CNT_W{1'b1}}) begin
        tsr_set.ovf = 1'b1;
        cnt_next    = tcr.arl ? tdr : {CNT_W{1'b0}};
      end else begin
        cnt_next = tcnt + CNT_W'(1);
      end
    end else if (tick && tcr.dir) begin
      if (tcnt == {CNT_W{1'b0}}) begin
        tsr_set.udf = 1'b1;
        cnt_next    = tcr.arl ? tdr : {CNT_W{1'b1}};
      end else begin
        cnt_next = tcnt - CNT_W'(1);
      end
    end else begin
      cnt_next = tcnt;
    end
  end

  // Channel state registers; a flag set beats a same-cycle W1C of that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdr  <= {CNT_W{1'b0}};
      tcnt <= {CNT_W{1'b0}};
      tcr  <= tcr_t'({$bits(tcr_t){1'b0}});
      tsr  <= tsr_t'(2'b00);
      tie  <= tsr_t'(2'b00);
      div  <= {DIV_W{1'b0}};
    end else begin
      tcnt <= cnt_next;
      tsr  <= tsr_t'((tsr & ~tsr_clr) | tsr_set);
      if (!tcr.en || load || cks_chg || tick) begin
        div <= {DIV_W{1'b0}};
      end else begin
        div <= div + DIV_W'(1);
      end
      if (wr_tdr) begin
        tdr <= wdata[CNT_W-1:0];
      end
      if (wr_tcr) begin
        tcr.en   <= wdata[TCR_EN];
        tcr.load <= 1'b0;
        tcr.dir  <= wdata[TCR_DIR];
        tcr.arl  <= wdata[TCR_ARL];
        tcr.cks  <= CKS_MAX_W'(new_cks);
      end
      if (wr_tie) begin
        tie <= tsr_t'(wdata[TSR_UDF:TSR_OVF]);
      end
    end
  end

  // Register read-back; LOAD and reserved TCR bits read as zero.
  always_comb begin
    case (sel)
      REG_TDR:  rdata = 32'(tdr);
      REG_TCR:  rdata = 32'({cks, tcr.arl, tcr.dir, 1'b0, tcr.en});
      REG_TSR:  rdata = 32'(tsr);
      REG_TIE:  rdata = 32'(tie);
      REG_TCNT: rdata = 32'(tcnt);
      default:  rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/timer_nch.sv
// N-channel timer with a zero-wait APB slave: address decode, read mux and error response.
module timer_nch
  import timer_nch_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 3,
  parameter int ADDR_W  = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);
  localparam int CH_IDX_W = ADDR_W - 5;

  logic                access, hit;
  logic [CH_IDX_W-1:0] ch_idx;
  reg_sel_e            sel;
  logic [31:0]         ch_rdata [NUM_CH];

  assign access  = psel && penable;
  assign ch_idx  = paddr[ADDR_W-1:5];
  assign sel     = decode_off(paddr[4:0]);
  assign hit     = (sel != REG_NONE) && (int'(ch_idx) < NUM_CH);
  assign pready  = 1'b1;
  assign pslverr = access && !hit;
  assign irq_any = |irq;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_nch_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk   (pclk),
      .rst   (preset),
      .wr    (access && pwrite && hit && (ch_idx == CH_IDX_W'(c))),
      .sel   (sel),
      .wdata (pwdata),
      .rdata (ch_rdata[c]),
      .irq   (irq[c])
    );
  end

  // Read data is driven only during a mapped access phase.
  always_comb begin
    prdata = 32'h0;
    if (access && hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        prdata = prdata | ((ch_idx == CH_IDX_W'(c)) ? ch_rdata[c] : 32'h0);
      end
    end else begin
      prdata = 32'h0;
    end
  end

endmodule

// File: tb/tb_timer_nch.sv
// Directed bench for timer_nch: register defaults, counting, prescaler, flags, irq and reset.
module tb_timer_nch;
  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq_any;
  logic [1:0]  irq;

  int checks = 0;
  int errors = 0;

  timer_nch #(.NUM_CH(2), .CNT_W(16), .PRESC_W(3), .ADDR_W(8)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq), .irq_any(irq_any)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk); penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk); penable = 1'b1; #1; d = prdata; e = pslverr;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_rd(a, d, e);
    check(tag, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          cks_list [4] = '{0, 1, 3, 7};
    int          m1;

    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b0;

    // Reset defaults
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    check("pready", 32'(pready), 32'h1);
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 5; r++) begin
        apb_rd(8'(c * 32 + r * 4), d, e);
        check($sformatf("rst_reg_c%0d_o%0h", c, r * 4), d, 32'h0);
        check($sformatf("rst_err_c%0d_o%0h", c, r * 4), 32'(e), 32'h0);
      end
    end
    apb_rd(8'h14, d, e);
    check("unmapped_data", d, 32'h0);
    check("unmapped_err", 32'(e), 32'h1);
    apb_rd(8'h40, d, e);
    check("bad_ch_err", 32'(e), 32'h1);
    apb_wr(8'h10, 32'h55);
    rd_chk("tcnt_ro", 8'h10, 32'h0);

    // Prescaler ratios on ch0: TCNT after edge m of enable equals m >> CKS
    for (int i = 0; i < 4; i++) begin
      apb_wr(8'h04, 32'h0);
      apb_wr(8'h00, 32'h0);
      apb_wr(8'h04, 32'h2);
      apb_wr(8'h04, 32'h1 | 32'(cks_list[i] << 4));
      if (cks_list[i] >= 2) idle((1 << cks_list[i]) - 2);
      m1 = (cks_list[i] >= 2) ? (1 << cks_list[i]) - 1 : 1;
      rd_chk($sformatf("presc%0d_a", cks_list[i]), 8'h10, 32'(m1 >> cks_list[i]));
      rd_chk($sformatf("presc%0d_b", cks_list[i]), 8'h10, 32'((m1 + 2) >> cks_list[i]));
    end

    // CKS change mid-count restarts the divider
    apb_wr(8'h04, 32'h0);
    apb_wr(8'h00, 32'h0);
    apb_wr(8'h04, 32'h2);
    apb_wr(8'h04, 32'h31);
    idle(4);
    apb_wr(8'h04, 32'h21);
    rd_chk("cks_restart_a", 8'h10, 32'h0);
    idle(1);
    rd_chk("cks_restart_b", 8'h10, 32'h1);
    apb_wr(8'h04, 32'h0);

    // Down count with auto-reload on ch1
    apb_wr(8'h20, 32'hFFFF_0005);
    rd_chk("tdr_upper_ignored", 8'h20, 32'h5);
    apb_wr(8'h2C, 32'h2);
    apb_wr(8'h24, 32'h2);
    apb_wr(8'h24, 32'hD);
    rd_chk("down_m1", 8'h30, 32'h4);
    idle(1);
    rd_chk("down_m4", 8'h30, 32'h1);
    rd_chk("down_reload", 8'h30, 32'h5);
    rd_chk("down_udf", 8'h28, 32'h2);
    rd_chk("tcr_readback", 8'h24, 32'hD);
    check("down_irq", 32'(irq), 32'h2);
    check("down_irq_any", 32'(irq_any), 32'h1);
    apb_wr(8'h24, 32'h0);
    apb_wr(8'h28, 32'h3);
    check("down_irq_clr", 32'(irq), 32'h0);

    // Up count to overflow on ch0, CKS=2
    apb_wr(8'h0C, 32'h0);
    apb_wr(8'h00, 32'hFFFD);
    apb_wr(8'h04, 32'h2);
    rd_chk("up_load", 8'h10, 32'hFFFD);
    apb_wr(8'h04, 32'h21);
    idle(3);
    rd_chk("up_fffe", 8'h10, 32'hFFFE);
    idle(2);
    rd_chk("up_ffff", 8'h10, 32'hFFFF);
    idle(2);
    rd_chk("up_wrap", 8'h10, 32'h0);
    rd_chk("up_ovf", 8'h08, 32'h1);
    check("up_irq_masked", 32'(irq), 32'h0);
    apb_wr(8'h0C, 32'h1);
    check("up_irq", 32'(irq), 32'h1);
    check("up_irq_any", 32'(irq_any), 32'h1);
    apb_wr(8'h0C, 32'h0);
    check("tie_clr_irq", 32'(irq), 32'h0);
    rd_chk("tie_clr_keeps_tsr", 8'h08, 32'h1);
    apb_wr(8'h0C, 32'h1);

    // W1C on the exact overflow edge: set wins
    apb_wr(8'h04, 32'h0);
    apb_wr(8'h08, 32'h3);
    check("race_pre_irq", 32'(irq), 32'h0);
    apb_wr(8'h00, 32'hFFFE);
    apb_wr(8'h04, 32'h3);
    apb_wr(8'h08, 32'h1);
    apb_wr(8'h04, 32'h0);
    rd_chk("race_ovf_kept", 8'h08, 32'h1);
    check("race_irq", 32'(irq), 32'h1);
    apb_wr(8'h08, 32'h1);
    check("w1c_irq_drop", 32'(irq), 32'h0);
    rd_chk("w1c_ovf_clr", 8'h08, 32'h0);

    // Reset mid-count with a same-cycle write
    apb_wr(8'h00, 32'hFFFF);
    apb_wr(8'h04, 32'h3);
    apb_wr(8'h04, 32'h0);
    apb_wr(8'h00, 32'h1234);
    apb_wr(8'h04, 32'h2);
    rd_chk("pre_rst_tcnt", 8'h10, 32'h1234);
    rd_chk("pre_rst_tsr", 8'h08, 32'h1);
    check("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge pclk);
    preset = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hABCD;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("rst_mid_irq", 32'(irq), 32'h0);
    check("rst_mid_irq_any", 32'(irq_any), 32'h0);
    rd_chk("rst_mid_tcnt", 8'h10, 32'h0);
    rd_chk("rst_mid_tsr", 8'h08, 32'h0);
    rd_chk("rst_mid_tdr", 8'h00, 32'h0);
    rd_chk("rst_mid_tie", 8'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
